// File: rtl/pc_fetch_ctrl.sv
// Multicycle fetch/execute sequencer driving PC update enable/select, with flush after redirects
// and a sticky instruction-memory timeout fault. Define PC_CTRL_PERF_EN to enable perf counters.
module pc_fetch_ctrl #(
  parameter int MEM_TIMEOUT  = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jmpFlag,
  input  logic        branchFlag,
  input  logic        zeroFlag,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        flush,
  output logic        fetch_fault,
  output logic [2:0]  state_dbg,
  output logic [31:0] retired_count,
  output logic [31:0] redirect_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_FLUSH = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          imem_req_q, imem_req_d;
  logic          instr_valid_q, instr_valid_d;
  logic          flush_q, flush_d;
  logic          fetch_fault_q, fetch_fault_d;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    pc_sel      = 2'b00;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_en = 1'b1;
          if (jmpFlag)                      pc_sel = 2'b10;
          else if (branchFlag && !zeroFlag) pc_sel = 2'b01;
          // A redirect with no flush window goes straight back to FETCH.
          if (pc_sel != 2'b00 && FLUSH_CYCLES > 0) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = S_FETCH;
            wait_d  = '0;
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == FW'(1)) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_EXEC);
    flush_d       = (state_d == S_FLUSH);
    fetch_fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_BOOT;
      wait_q        <= '0;
      flush_cnt_q   <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      flush_cnt_q   <= flush_cnt_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign flush       = flush_q;
  assign fetch_fault = fetch_fault_q;
  assign state_dbg   = state_q;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] redirect_q, redirect_d;

  always_comb begin
    retired_d  = retired_q;
    redirect_d = redirect_q;
    if (pc_en) begin
      retired_d = retired_q + 32'd1;
      if (pc_sel != 2'b00) redirect_d = redirect_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retired_q  <= '0;
      redirect_q <= '0;
    end else begin
      retired_q  <= retired_d;
      redirect_q <= redirect_d;
    end
  end

  assign retired_count  = retired_q;
  assign redirect_count = redirect_q;
`else
  assign retired_count  = '0;
  assign redirect_count = '0;
`endif

endmodule
